// File: rtl/uart_fifo_mapped.sv
// rtl/uart_fifo_mapped.sv - register-mapped UART with RX/TX FIFOs, programmable divisor and IRQ
module uart_fifo_mapped #(
  parameter int         DATA_WIDTH   = 8,
  parameter int         FIFO_ADDR_W  = 4,
  parameter logic [7:0] DIV_RESET    = 8'd15,
  parameter logic [2:0] COMPONENT_ID = 3'b000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  rx_in,
  output logic                  tx_out,
  output logic                  irq,
  output logic [2:0]            irq_id
);
  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] FULL_CNT = (FIFO_ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic r_rd_q, r_wr_q;
  logic w_rd_lvl, w_wr_lvl, w_rd_acc, w_wr_acc, w_data_rd, w_data_wr, w_stat_wr;
  logic [2:0] r_ctrl;
  logic r_rx_flush, r_tx_flush;
  logic [7:0] r_div, r_out, w_div_eff, w_rx_half, w_status;
  logic r_tx_ovf, r_rx_ovr, r_frame_err, r_irq;

  logic [7:0] r_tx_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] r_tx_wp, r_tx_rp;
  logic [FIFO_ADDR_W:0] r_tx_cnt;
  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;

  logic [7:0] r_rx_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] r_rx_wp, r_rx_rp;
  logic [FIFO_ADDR_W:0] r_rx_cnt;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;

  tx_state_t r_tx_state;
  logic r_tx_out;
  logic [7:0] r_tx_tmr, r_tx_shift;
  logic [2:0] r_tx_bit;

  rx_state_t r_rx_state;
  logic r_rx_s1, r_rx_s2, r_rx_s3, r_rx_push_q;
  logic [7:0] r_rx_tmr, r_rx_shift, r_rx_byte;
  logic [2:0] r_rx_bit;

  // Accesses fire only on the first cycle a strobe is seen low with cs.
  assign w_rd_lvl  = ~cs & ~rd;
  assign w_wr_lvl  = ~cs & ~wr;
  assign w_rd_acc  = w_rd_lvl & ~r_rd_q;
  assign w_wr_acc  = w_wr_lvl & ~r_wr_q;
  assign w_data_rd = w_rd_acc & (addr == 2'd3);
  assign w_data_wr = w_wr_acc & (addr == 2'd3);
  assign w_stat_wr = w_wr_acc & (addr == 2'd0);

  assign w_div_eff = (r_div == 8'd0) ? 8'd1 : r_div;
  // Half-bit delay minus one, so the start bit is resampled (DIVISOR+1)/2 clocks after the edge.
  assign w_rx_half = (w_div_eff - 8'd1) >> 1;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);

  assign w_tx_push = w_data_wr & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & ~r_tx_flush &
                     ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & (r_tx_tmr == 8'd0)));
  assign w_rx_push = r_rx_push_q & ~w_rx_full;
  assign w_rx_pop  = w_data_rd & ~w_rx_empty;

  assign w_status = {(r_tx_state != TX_IDLE), r_tx_ovf, r_frame_err, r_rx_ovr,
                     w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

  assign out_data = r_out;
  assign tx_out   = r_tx_out;
  assign irq      = r_irq;
  assign irq_id   = COMPONENT_ID;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_q     <= 1'b0;
      r_wr_q     <= 1'b0;
      r_out      <= 8'd0;
      r_ctrl     <= 3'd0;
      r_rx_flush <= 1'b0;
      r_tx_flush <= 1'b0;
      r_div      <= DIV_RESET;
      r_tx_ovf   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rd_q     <= w_rd_lvl;
      r_wr_q     <= w_wr_lvl;
      r_rx_flush <= 1'b0;
      r_tx_flush <= 1'b0;
      if (w_rd_acc) begin
        case (addr)
          2'd0: r_out <= w_status;
          2'd1: r_out <= {5'd0, r_ctrl};
          2'd2: r_out <= r_div;
          2'd3: r_out <= w_rx_empty ? 8'd0 : r_rx_mem[r_rx_rp];
        endcase
      end
      if (w_wr_acc) begin
        case (addr)
          2'd1: begin
            r_ctrl     <= in_data[2:0];
            r_rx_flush <= in_data[3];
            r_tx_flush <= in_data[4];
          end
          2'd2: r_div <= in_data;
          default: ;
        endcase
      end
      if (w_data_wr && w_tx_full)
        r_tx_ovf <= 1'b1;
      else if (w_stat_wr && in_data[6])
        r_tx_ovf <= 1'b0;
      r_irq <= (r_ctrl[0] & ~w_rx_empty) |
               (r_ctrl[1] & w_tx_empty & (r_tx_state == TX_IDLE)) |
               (r_ctrl[2] & (r_rx_ovr | r_frame_err | r_tx_ovf));
    end
  end

  always_ff @(posedge clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= in_data;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_byte;
  end

  // Flush takes priority over any same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (!reset || r_tx_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || r_rx_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  // Bit timers reload from the divisor at every bit boundary, so divisor changes land there.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_out   <= 1'b1;
      r_tx_tmr   <= 8'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_out <= 1'b1;
          if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rp];
            r_tx_out   <= 1'b0;
            r_tx_tmr   <= w_div_eff;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_tmr != 8'd0) r_tx_tmr <= r_tx_tmr - 8'd1;
          else begin
            r_tx_out   <= r_tx_shift[0];
            r_tx_tmr   <= w_div_eff;
            r_tx_bit   <= 3'd0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (r_tx_tmr != 8'd0) r_tx_tmr <= r_tx_tmr - 8'd1;
          else begin
            r_tx_tmr <= w_div_eff;
            if (r_tx_bit == 3'd7) begin
              r_tx_out   <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_out   <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (r_tx_tmr != 8'd0) r_tx_tmr <= r_tx_tmr - 8'd1;
          else if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rp];
            r_tx_out   <= 1'b0;
            r_tx_tmr   <= w_div_eff;
            r_tx_state <= TX_START;
          end else begin
            r_tx_state <= TX_IDLE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_s3     <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_tmr    <= 8'd0;
      r_rx_bit    <= 3'd0;
      r_rx_shift  <= 8'd0;
      r_rx_push_q <= 1'b0;
      r_rx_byte   <= 8'd0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1     <= rx_in;
      r_rx_s2     <= r_rx_s1;
      r_rx_s3     <= r_rx_s2;
      r_rx_push_q <= 1'b0;
      if (w_stat_wr && in_data[4]) r_rx_ovr    <= 1'b0;
      if (w_stat_wr && in_data[5]) r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rx_tmr   <= w_rx_half;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_tmr != 8'd0) r_rx_tmr <= r_rx_tmr - 8'd1;
          else if (r_rx_s2) r_rx_state <= RX_IDLE;
          else begin
            r_rx_tmr   <= w_div_eff;
            r_rx_bit   <= 3'd0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_tmr != 8'd0) r_rx_tmr <= r_rx_tmr - 8'd1;
          else begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_tmr   <= w_div_eff;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_tmr != 8'd0) r_rx_tmr <= r_rx_tmr - 8'd1;
          else begin
            r_rx_state <= RX_IDLE;
            if (!r_rx_s2)       r_frame_err <= 1'b1;
            else if (w_rx_full) r_rx_ovr    <= 1'b1;
            else begin
              r_rx_push_q <= 1'b1;
              r_rx_byte   <= r_rx_shift;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_mapped.sv
// tb/tb_uart_fifo_mapped.sv - directed and randomized checks of uart_fifo_mapped against a queue-based model
module tb_uart_fifo_mapped;
  logic clk = 1'b0;
  logic resetn, cs_big, cs_small, rd_n, wr_n, rx_big, rx_small;
  logic [1:0] addr;
  logic [7:0] wdata, out_big, out_small, rv, d;
  logic tx_big, tx_small, irq_big, irq_small;
  logic [2:0] id_big, id_small;
  logic [7:0] rxq[$];
  int n_pass = 0, n_total = 0, n_fail = 0;
  int dv, per, exp_st;
  bit ovr_model;

  always #5 clk = ~clk;

  uart_fifo_mapped u_big (
    .clock(clk), .reset(resetn), .cs(cs_big), .rd(rd_n), .wr(wr_n), .addr(addr),
    .in_data(wdata), .out_data(out_big), .rx_in(rx_big), .tx_out(tx_big),
    .irq(irq_big), .irq_id(id_big)
  );

  uart_fifo_mapped #(.FIFO_ADDR_W(2), .COMPONENT_ID(3'b101)) u_small (
    .clock(clk), .reset(resetn), .cs(cs_small), .rd(rd_n), .wr(wr_n), .addr(addr),
    .in_data(wdata), .out_data(out_small), .rx_in(rx_small), .tx_out(tx_small),
    .irq(irq_small), .irq_id(id_small)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input bit sel_small, input logic [1:0] a, input logic [7:0] v);
    addr = a; wdata = v; wr_n = 1'b0;
    if (sel_small) cs_small = 1'b0; else cs_big = 1'b0;
    tick();
    wr_n = 1'b1; cs_small = 1'b1; cs_big = 1'b1;
    tick();
  endtask

  task automatic bus_read(input bit sel_small, input logic [1:0] a, output logic [7:0] v);
    addr = a; rd_n = 1'b0;
    if (sel_small) cs_small = 1'b0; else cs_big = 1'b0;
    tick();
    rd_n = 1'b1; cs_small = 1'b1; cs_big = 1'b1;
    v = sel_small ? out_small : out_big;
    tick();
  endtask

  task automatic send_rx(input bit sel_small, input logic [7:0] v, input logic stop, input int p);
    logic [9:0] fr;
    fr = {stop, v, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (sel_small) rx_small = fr[b]; else rx_big = fr[b];
      repeat (p) tick();
    end
    rx_small = 1'b1; rx_big = 1'b1;
    repeat (2 * p + 4) tick();
  endtask

  task automatic check_tx_frame(input logic [7:0] v, input int p);
    logic [9:0] fr;
    int waited;
    fr = {1'b1, v, 1'b0};
    waited = 0;
    while (tx_big !== 1'b0 && waited < 64) begin
      tick();
      waited++;
    end
    check("tx_start_seen", 32'(waited < 64), 1);
    if (waited < 64) begin
      for (int i = 0; i < 10 * p; i++) begin
        check("tx_bit", tx_big, fr[i / p]);
        tick();
      end
    end
  endtask

  initial begin
    resetn = 1'b0; cs_big = 1'b1; cs_small = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = 2'd0; wdata = 8'd0; rx_big = 1'b1; rx_small = 1'b1;
    repeat (3) tick();
    check("rst_tx_out", tx_big, 1);
    check("rst_out_data", out_big, 0);
    check("rst_irq", irq_big, 0);
    check("rst_irq_id_big", id_big, 0);
    check("rst_irq_id_small", id_small, 3'b101);
    resetn = 1'b1;
    tick();
    bus_read(0, 2'd0, rv); check("rst_status", rv, 8'h04);
    bus_read(0, 2'd2, rv); check("rst_divisor", rv, 8'h0F);
    bus_read(0, 2'd1, rv); check("rst_control", rv, 8'h00);

    // TX framing, fixed byte then random bytes and divisors (0 behaves as 1)
    bus_write(0, 2'd2, 8'd3);
    bus_write(0, 2'd3, 8'hA5);
    check_tx_frame(8'hA5, 4);
    bus_read(0, 2'd0, rv); check("tx_done_status", rv, 8'h04);
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      dv = $urandom_range(0, 4);
      per = ((dv == 0) ? 1 : dv) + 1;
      bus_write(0, 2'd2, 8'(dv));
      bus_write(0, 2'd3, d);
      check_tx_frame(d, per);
    end

    // RX to read, empty read, TX-empty interrupt
    bus_write(0, 2'd2, 8'd3);
    send_rx(0, 8'h3C, 1'b1, 4);
    bus_read(0, 2'd0, rv); check("rx_status_full", rv, 8'h05);
    bus_read(0, 2'd3, rv); check("rx_data", rv, 8'h3C);
    bus_read(0, 2'd0, rv); check("rx_status_after", rv, 8'h04);
    bus_read(0, 2'd3, rv); check("rx_empty_read", rv, 8'h00);
    bus_read(0, 2'd0, rv); check("rx_empty_status", rv, 8'h04);
    bus_write(0, 2'd1, 8'h02);
    check("tx_irq_on", irq_big, 1);
    bus_write(0, 2'd1, 8'h00);
    check("tx_irq_off", irq_big, 0);

    // Random bytes at random divisors, queued by the model
    bus_write(0, 2'd1, 8'h01);
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      dv = $urandom_range(2, 5);
      bus_write(0, 2'd2, 8'(dv));
      send_rx(0, d, 1'b1, dv + 1);
      rxq.push_back(d);
    end
    check("rx_irq_on", irq_big, 1);
    while (rxq.size() > 0) begin
      bus_read(0, 2'd3, rv);
      check("rx_rand_data", rv, rxq.pop_front());
    end
    tick();
    check("rx_irq_off", irq_big, 0);
    bus_write(0, 2'd1, 8'h00);

    // Overrun on the 4-deep instance
    bus_write(1, 2'd2, 8'd3);
    ovr_model = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      send_rx(1, d, 1'b1, 4);
      if (rxq.size() < 4) rxq.push_back(d); else ovr_model = 1'b1;
    end
    exp_st = ((rxq.size() > 0) ? 1 : 0) + ((rxq.size() == 4) ? 2 : 0) + 4 + (ovr_model ? 16 : 0);
    bus_read(1, 2'd0, rv); check("ovr_status", rv, 32'(exp_st));
    while (rxq.size() > 0) begin
      bus_read(1, 2'd3, rv);
      check("ovr_data", rv, rxq.pop_front());
    end
    bus_write(1, 2'd0, 8'h10);
    bus_read(1, 2'd0, rv); check("ovr_cleared", rv, 8'h04);

    // Framing error, error interrupt, flush bits read as zero
    bus_write(0, 2'd2, 8'd3);
    send_rx(0, 8'($urandom), 1'b0, 4);
    bus_read(0, 2'd0, rv); check("ferr_status", rv, 8'h24);
    bus_write(0, 2'd1, 8'h04);
    check("ferr_irq", irq_big, 1);
    bus_read(0, 2'd1, rv); check("ctrl_readback", rv, 8'h04);
    bus_write(0, 2'd0, 8'h20);
    tick();
    check("ferr_irq_clear", irq_big, 0);
    bus_read(0, 2'd0, rv); check("ferr_cleared", rv, 8'h04);
    bus_write(0, 2'd1, 8'h1F);
    bus_read(0, 2'd1, rv); check("ctrl_flush_reads_0", rv, 8'h07);
    bus_write(0, 2'd1, 8'h00);

    // Held strobe gives one push; 16 more fill the FIFO, the 17th overflows
    bus_write(0, 2'd2, 8'd255);
    addr = 2'd3; wdata = 8'h00; cs_big = 1'b0; wr_n = 1'b0;
    repeat (10) tick();
    cs_big = 1'b1; wr_n = 1'b1;
    tick();
    bus_read(0, 2'd0, rv); check("held_one_push", rv, 8'h84);
    for (int k = 0; k < 16; k++) bus_write(0, 2'd3, 8'($urandom));
    bus_read(0, 2'd0, rv); check("tx_full_no_ovf", rv, 8'h88);
    bus_write(0, 2'd3, 8'($urandom));
    bus_read(0, 2'd0, rv); check("tx_overflow", rv, 8'hC8);
    bus_write(0, 2'd1, 8'h10);
    bus_read(0, 2'd0, rv); check("tx_flushed", rv, 8'hC4);

    // Reset in the middle of the data bits
    repeat (400) tick();
    check("tx_mid_data", tx_big, 0);
    resetn = 1'b0;
    tick();
    check("rst_mid_tx_out", tx_big, 1);
    resetn = 1'b1;
    tick();
    bus_read(0, 2'd0, rv); check("rst_mid_status", rv, 8'h04);
    bus_read(0, 2'd2, rv); check("rst_mid_divisor", rv, 8'h0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
